// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the 1-to-5 stream demultiplexer.
// Optional feature macro used by the top level: STREAM_DEMUX5_DROP_CNT_EN.
package stream_demux_pkg;

  localparam int N_DEST = 5;
  localparam int DEST_W = 3;

  typedef enum logic [DEST_W-1:0] {
    DEST0 = 3'd0,
    DEST1 = 3'd1,
    DEST2 = 3'd2,
    DEST3 = 3'd3,
    DEST4 = 3'd4
  } dest_e;

  // A destination tag addresses a real channel only for codes 0..4.
  function automatic logic dest_in_range(input logic [DEST_W-1:0] dest);
    return (dest <= DEST4);
  endfunction

endpackage

// File: rtl/stream_hold_reg.sv
// Single-entry holding register: valid flag, data word and destination tag.
// load captures a new word; clear empties the stage when nothing is loaded.
module stream_hold_reg
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [WIDTH-1:0]  load_data,
  input  logic [DEST_W-1:0] load_dest,
  output logic              hold_vld,
  output logic [WIDTH-1:0]  hold_data,
  output logic [DEST_W-1:0] hold_dest
);

  logic              vld_reg;
  logic [WIDTH-1:0]  data_reg;
  logic [DEST_W-1:0] dest_reg;

  // Load has priority over clear so a drain plus accept keeps the stage full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_reg  <= 1'b0;
      data_reg <= '0;
      dest_reg <= '0;
    end else if (load) begin
      vld_reg  <= 1'b1;
      data_reg <= load_data;
      dest_reg <= load_dest;
    end else if (clear) begin
      vld_reg  <= 1'b0;
    end
  end

  assign hold_vld  = vld_reg;
  assign hold_data = data_reg;
  assign hold_dest = dest_reg;

endmodule

// File: rtl/stream_demux5.sv
// 1-to-5 registered stream demultiplexer with one-entry holding stage.
// Words tagged with destination 5..7 are consumed and reported on drop_pulse.
// Optional macro STREAM_DEMUX5_DROP_CNT_EN adds a saturating 8-bit drop counter.
module stream_demux5
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [DEST_W-1:0] in_dest,
  output logic [N_DEST-1:0] out_valid,
  input  logic [N_DEST-1:0] out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              drop_pulse
`ifdef STREAM_DEMUX5_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  logic              hold_vld;
  logic [WIDTH-1:0]  hold_data;
  logic [DEST_W-1:0] hold_dest;
  logic              drain;
  logic              accept;
  logic              in_range;
  logic              load;
  logic              clear;
  logic              drop_pulse_reg;

  stream_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .clear    (clear),
    .load_data(in_data),
    .load_dest(in_dest),
    .hold_vld (hold_vld),
    .hold_data(hold_data),
    .hold_dest(hold_dest)
  );

  // Destination decode: only the channel named by the held tag sees valid.
  genvar gi;
  generate
    for (gi = 0; gi < N_DEST; gi++) begin : g_decode
      assign out_valid[gi] = hold_vld && (hold_dest == DEST_W'(gi));
    end
  endgenerate

  // Handshake and hold-stage control; drain is derived from the decoded
  // valids so an unused tag value can never select a ready bit.
  always_comb begin
    drain    = |(out_valid & out_ready);
    in_ready = !hold_vld || drain;
    accept   = in_valid && in_ready;
    in_range = dest_in_range(in_dest);
    load     = accept && in_range;
    clear    = drain && !load;
  end

  assign out_data = hold_data;

  // Registered one-cycle pulse for every consumed out-of-range word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_pulse_reg <= 1'b0;
    end else begin
      drop_pulse_reg <= accept && !in_range;
    end
  end

  assign drop_pulse = drop_pulse_reg;

`ifdef STREAM_DEMUX5_DROP_CNT_EN
  logic [7:0] drop_cnt_reg;

  // Saturating count of drop pulses; sticks at 8'hFF.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_reg <= 8'd0;
    end else if (drop_pulse_reg && (drop_cnt_reg != 8'hFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_stream_demux5.sv
// Directed bench for stream_demux5 with a queue-based reference model.
module tb_stream_demux5;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [2:0]   in_dest;
  logic [4:0]   out_valid;
  logic [4:0]   out_ready;
  logic [W-1:0] out_data;
  logic         drop_pulse;
`ifdef STREAM_DEMUX5_DROP_CNT_EN
  logic [7:0]   drop_cnt;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Reference: list of words in flight, each {dest, data}
  logic [W+2:0] q[$];
  bit           m_drop;
  int           m_cnt;
  bit           m_drain;
  bit           m_rdy;

  stream_demux5 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .drop_pulse(drop_pulse)
`ifdef STREAM_DEMUX5_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Model update: a word is delivered when its channel is ready, a new word
  // is accepted when nothing is held or the held word leaves this cycle.
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_drop = 1'b0;
      m_cnt  = 0;
    end else begin
      m_drain = (q.size() > 0) && out_ready[q[0][W+2:W]];
      m_rdy   = (q.size() == 0) || m_drain;
      if (m_drain) void'(q.pop_front());
      m_drop = 1'b0;
      if (in_valid && m_rdy) begin
        if (in_dest <= 3'd4) q.push_back({in_dest, in_data});
        else m_drop = 1'b1;
      end
      if (m_drop && m_cnt < 255) m_cnt++;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      if (q.size() > 0) begin
        check("m_valid", {27'd0, out_valid}, {27'd0, 5'b00001 << q[0][W+2:W]});
        check("m_data", out_data, q[0][W-1:0]);
        check("m_ready", {31'd0, in_ready}, {31'd0, out_ready[q[0][W+2:W]]});
      end else begin
        check("m_valid", {27'd0, out_valid}, 32'd0);
        check("m_ready", {31'd0, in_ready}, 32'd1);
      end
      check("m_drop", {31'd0, drop_pulse}, {31'd0, m_drop});
`ifdef STREAM_DEMUX5_DROP_CNT_EN
      check("m_cnt", {24'd0, drop_cnt}, m_cnt);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic [2:0] dst);
    in_valid = 1'b1;
    in_data  = d;
    in_dest  = dst;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_BEEF;
    in_dest   = 3'd0;
    out_ready = 5'h1F;

    // Reset with in_valid asserted
    step();
    step();
    chk_en = 1'b1;
    rst_n  = 1'b1;
    in_valid = 1'b0;
    check("rst_out_valid", {27'd0, out_valid}, 32'd0);
    check("rst_drop", {31'd0, drop_pulse}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_data", out_data, 32'd0);
    $display("reset released: out_valid=%b in_ready=%b", out_valid, in_ready);

    // Single routes
    for (int k = 0; k < 5; k++) begin
      send(32'hA5A5_0000 + k, 3'(k));
      step();
      in_valid = 1'b0;
      check("route_valid", {27'd0, out_valid}, {27'd0, 5'b00001 << k});
      check("route_data", out_data, 32'hA5A5_0000 + k);
      $display("route dest=%0d out_valid=%b data=%h", k, out_valid, out_data);
      step();
    end

    // Back-to-back stream
    for (int i = 0; i < 8; i++) begin
      send(32'hB000_0000 + i, 3'(i % 5));
      check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      $display("b2b word %0d dest=%0d out_valid=%b data=%h", i, i % 5, out_valid, out_data);
    end
    in_valid = 1'b0;
    step();

    // Backpressure on channel 2
    out_ready = 5'b11011;
    send(32'h1234, 3'd2);
    step();
    send(32'h5678, 3'd3);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    step();
    check("bp_valid", {27'd0, out_valid}, 32'b00100);
    check("bp_data", out_data, 32'h1234);
    check("bp_in_ready2", {31'd0, in_ready}, 32'd0);
    $display("stalled: out_valid=%b data=%h in_ready=%b", out_valid, out_data, in_ready);
    out_ready = 5'h1F;
    step();
    in_valid = 1'b0;
    check("bp_next_valid", {27'd0, out_valid}, 32'b01000);
    check("bp_next_data", out_data, 32'h5678);
    $display("released: out_valid=%b data=%h", out_valid, out_data);
    step();

    // Out-of-range destinations
    for (int d = 5; d < 8; d++) begin
      send(32'hC000_0000 + d, 3'(d));
      check("oor_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      check("oor_drop", {31'd0, drop_pulse}, 32'd1);
      check("oor_valid", {27'd0, out_valid}, 32'd0);
      $display("drop dest=%0d drop_pulse=%b", d, drop_pulse);
    end
    in_valid = 1'b0;
    step();
    check("oor_drop_end", {31'd0, drop_pulse}, 32'd0);
`ifdef STREAM_DEMUX5_DROP_CNT_EN
    check("drop_cnt3", {24'd0, drop_cnt}, 32'd3);
`endif
    send(32'hC0DE, 3'd7);
    repeat (300) step();
    in_valid = 1'b0;
    step();
`ifdef STREAM_DEMUX5_DROP_CNT_EN
    check("drop_cnt_sat", {24'd0, drop_cnt}, 32'hFF);
    $display("drop_cnt after saturation=%h", drop_cnt);
`endif

    // Mid-operation reset discards the held word
    out_ready = 5'b11110;
    send(32'hFEED_0001, 3'd0);
    step();
    in_valid = 1'b0;
    check("mid_hold", {27'd0, out_valid}, 32'b00001);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_valid", {27'd0, out_valid}, 32'd0);
    out_ready = 5'h1F;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_no_deliver", {27'd0, out_valid}, 32'd0);
    end
    $display("mid reset: out_valid=%b after ready returned", out_valid);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
